// File: rtl/mem_arbiter_if.sv
// Request/response bundle shared by mem_arbiter, the icache, the load/store
// buffer and the byte-serial memory controller.
interface mem_arbiter_if #(
    parameter int LINE_WORDS = 4
);
    localparam int IDX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    logic             if_valid;
    logic [31:0]      if_addr;
    logic             if_word_valid;
    logic [IDX_W-1:0] if_word_idx;
    logic [31:0]      if_word;
    logic             if_done;

    logic             ls_valid;
    logic             ls_wr;
    logic [31:0]      ls_addr;
    logic [2:0]       ls_len;
    logic [31:0]      ls_data;
    logic             ls_ready;
    logic [31:0]      ls_res;

    logic             mc_valid;
    logic             mc_wr;
    logic [31:0]      mc_addr;
    logic [2:0]       mc_len;
    logic [31:0]      mc_data;
    logic             mc_ready;
    logic [31:0]      mc_res;

    // Arbiter-side view: serves the two requesters, drives the controller.
    modport slave (
        input  if_valid, if_addr, ls_valid, ls_wr, ls_addr, ls_len, ls_data,
               mc_ready, mc_res,
        output if_word_valid, if_word_idx, if_word, if_done, ls_ready, ls_res,
               mc_valid, mc_wr, mc_addr, mc_len, mc_data
    );

    modport master (
        output if_valid, if_addr, ls_valid, ls_wr, ls_addr, ls_len, ls_data,
               mc_ready, mc_res,
        input  if_word_valid, if_word_idx, if_word, if_done, ls_ready, ls_res,
               mc_valid, mc_wr, mc_addr, mc_len, mc_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the memory controller between icache line refills and single
// load/store accesses; a refill is expanded into LINE_WORDS word reads.
module mem_arbiter #(
    parameter int LINE_WORDS = 4
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         rdy_in,
    input  logic         clear_in,
    mem_arbiter_if.slave bus
);
    localparam int IDX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic [1:0]       state_q, state_d;
    logic             lastGrant_q, lastGrant_d;
    logic [IDX_W-1:0] wordCnt_q, wordCnt_d;
    logic             cancel_q, cancel_d;

    logic             mcValid_q, mcValid_d;
    logic             mcWr_q, mcWr_d;
    logic [31:0]      mcAddr_q, mcAddr_d;
    logic [2:0]       mcLen_q, mcLen_d;
    logic [31:0]      mcData_q, mcData_d;

    logic             wordValid_q, wordValid_d;
    logic [IDX_W-1:0] wordIdx_q, wordIdx_d;
    logic [31:0]      word_q, word_d;
    logic             ifDone_q, ifDone_d;
    logic             lsReady_q, lsReady_d;
    logic [31:0]      lsRes_q, lsRes_d;

    logic grantI;
    logic cancelNow;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grantI    = bus.if_valid & ~clear_in & (~bus.ls_valid | (lastGrant_q == GRANT_D));
        cancelNow = cancel_q | clear_in;
    end

    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        wordCnt_d   = wordCnt_q;
        cancel_d    = cancel_q;
        mcValid_d   = mcValid_q;
        mcWr_d      = mcWr_q;
        mcAddr_d    = mcAddr_q;
        mcLen_d     = mcLen_q;
        mcData_d    = mcData_q;
        wordValid_d = wordValid_q;
        wordIdx_d   = wordIdx_q;
        word_d      = word_q;
        ifDone_d    = ifDone_q;
        lsReady_d   = lsReady_q;
        lsRes_d     = lsRes_q;

        if (rdy_in) begin
            wordValid_d = 1'b0;
            ifDone_d    = 1'b0;
            lsReady_d   = 1'b0;
            case (state_q)
                IDLE: begin
                    if (grantI) begin
                        mcValid_d   = 1'b1;
                        mcWr_d      = 1'b0;
                        mcLen_d     = 3'b010;
                        mcAddr_d    = bus.if_addr;
                        wordCnt_d   = '0;
                        cancel_d    = 1'b0;
                        lastGrant_d = GRANT_I;
                        state_d     = BUSY_I;
                    end else if (bus.ls_valid) begin
                        mcValid_d   = 1'b1;
                        mcWr_d      = bus.ls_wr;
                        mcLen_d     = bus.ls_len;
                        mcAddr_d    = bus.ls_addr;
                        mcData_d    = bus.ls_data;
                        lastGrant_d = GRANT_D;
                        state_d     = BUSY_D;
                    end
                end
                BUSY_I: begin
                    // The word in flight cannot be aborted; a flush only drops its data.
                    cancel_d = cancelNow;
                    if (bus.mc_ready) begin
                        if (!cancelNow) begin
                            wordValid_d = 1'b1;
                            wordIdx_d   = wordCnt_q;
                            word_d      = bus.mc_res;
                        end
                        if (!cancelNow && (wordCnt_q != LAST_IDX)) begin
                            wordCnt_d = wordCnt_q + IDX_W'(1);
                            mcAddr_d  = mcAddr_q + 32'd4;
                        end else begin
                            mcValid_d = 1'b0;
                            ifDone_d  = 1'b1;
                            state_d   = DONE;
                        end
                    end
                end
                BUSY_D: begin
                    if (bus.mc_ready) begin
                        lsRes_d   = mcWr_q ? 32'd0 : bus.mc_res;
                        lsReady_d = 1'b1;
                        mcValid_d = 1'b0;
                        state_d   = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            lastGrant_q <= GRANT_D;
            wordCnt_q   <= '0;
            cancel_q    <= 1'b0;
            mcValid_q   <= 1'b0;
            mcWr_q      <= 1'b0;
            mcAddr_q    <= '0;
            mcLen_q     <= '0;
            mcData_q    <= '0;
            wordValid_q <= 1'b0;
            wordIdx_q   <= '0;
            word_q      <= '0;
            ifDone_q    <= 1'b0;
            lsReady_q   <= 1'b0;
            lsRes_q     <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            wordCnt_q   <= wordCnt_d;
            cancel_q    <= cancel_d;
            mcValid_q   <= mcValid_d;
            mcWr_q      <= mcWr_d;
            mcAddr_q    <= mcAddr_d;
            mcLen_q     <= mcLen_d;
            mcData_q    <= mcData_d;
            wordValid_q <= wordValid_d;
            wordIdx_q   <= wordIdx_d;
            word_q      <= word_d;
            ifDone_q    <= ifDone_d;
            lsReady_q   <= lsReady_d;
            lsRes_q     <= lsRes_d;
        end
    end

    assign bus.mc_valid      = mcValid_q;
    assign bus.mc_wr         = mcWr_q;
    assign bus.mc_addr       = mcAddr_q;
    assign bus.mc_len        = mcLen_q;
    assign bus.mc_data       = mcData_q;
    assign bus.if_word_valid = wordValid_q;
    assign bus.if_word_idx   = wordIdx_q;
    assign bus.if_word       = word_q;
    assign bus.if_done       = ifDone_q;
    assign bus.ls_ready      = lsReady_q;
    assign bus.ls_res        = lsRes_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level reference model is compared
// against every output on every cycle, plus table vectors and corner sequences.
module tb_mem_arbiter;
    localparam int LW    = 4;
    localparam int IDX_W = 2;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b1;
    logic rdy_in   = 1'b1;
    logic clear_in = 1'b0;

    int tests    = 0;
    int failures = 0;

    mem_arbiter_if #(.LINE_WORDS(LW)) bus ();

    mem_arbiter #(.LINE_WORDS(LW)) dut (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .rdy_in  (rdy_in),
        .clear_in(clear_in),
        .bus     (bus)
    );

    always #5 clk_in = ~clk_in;

    logic             eMcValid, eMcWr, eWordValid, eDone, eLsReady;
    logic [31:0]      eMcAddr, eMcData, eWord, eLsRes;
    logic [2:0]       eMcLen;
    logic [IDX_W-1:0] eWordIdx;
    int               owner;
    bit               cooldown, lastWasIcache, cancelled;
    logic [31:0]      lineBase;
    int               idxQ[$];

    bit ctrlOn     = 1'b0;
    int ctrlCnt    = 0;
    int ctrlMaxLat = 0;

    typedef struct packed {
        logic        lsValid;
        logic        lsWr;
        logic [31:0] lsAddr;
        logic [2:0]  lsLen;
        logic [31:0] lsData;
        logic        mcReady;
        logic [31:0] mcRes;
        logic        expMcValid;
        logic        expMcWr;
        logic [31:0] expMcAddr;
        logic        expLsReady;
        logic [31:0] expLsRes;
    } vec_t;
    vec_t vecs[10];

    logic [31:0] addrs[$];
    logic [31:0] grants[$];
    int          words;
    bit          gotDone, prevValid, cleared, sawGrant, lsDone;
    logic [31:0] prevAddr;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1234};
    endfunction

    function automatic vec_t mkVec(input logic v, input logic w, input logic [31:0] a,
                                   input logic [2:0] l, input logic [31:0] d,
                                   input logic r, input logic [31:0] res,
                                   input logic eV, input logic eW, input logic [31:0] eA,
                                   input logic eR, input logic [31:0] eRes);
        vec_t x;
        x = '{v, w, a, l, d, r, res, eV, eW, eA, eR, eRes};
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        eMcValid = 0; eMcWr = 0; eMcAddr = 0; eMcLen = 0; eMcData = 0;
        eWordValid = 0; eWordIdx = 0; eWord = 0; eDone = 0; eLsReady = 0; eLsRes = 0;
        owner = 0; cooldown = 0; lastWasIcache = 0; cancelled = 0; lineBase = 0;
        idxQ.delete();
    endtask

    // Evaluated right after each edge using the inputs that edge sampled.
    task automatic modelEdge();
        int  idx;
        bit  wantI, wantD;
        if (!rst_n_in) begin
            modelReset();
            return;
        end
        if (!rdy_in) return;
        eWordValid = 0; eDone = 0; eLsReady = 0;
        if (cooldown) begin
            cooldown = 0;
            return;
        end
        case (owner)
            0: begin
                wantI = bus.if_valid && !clear_in;
                wantD = bus.ls_valid;
                if (wantI && (!wantD || !lastWasIcache)) begin
                    owner = 1; lastWasIcache = 1; cancelled = 0; lineBase = bus.if_addr;
                    idxQ.delete();
                    for (int k = 0; k < LW; k++) idxQ.push_back(k);
                    eMcValid = 1; eMcWr = 0; eMcLen = 3'b010; eMcAddr = bus.if_addr;
                end else if (wantD) begin
                    owner = 2; lastWasIcache = 0;
                    eMcValid = 1; eMcWr = bus.ls_wr; eMcAddr = bus.ls_addr;
                    eMcLen = bus.ls_len; eMcData = bus.ls_data;
                end
            end
            1: begin
                if (clear_in) cancelled = 1;
                if (bus.mc_ready) begin
                    idx = idxQ.pop_front();
                    if (!cancelled) begin
                        eWordValid = 1; eWordIdx = IDX_W'(idx); eWord = bus.mc_res;
                    end
                    if (idxQ.size() != 0 && !cancelled) begin
                        eMcAddr = lineBase + 32'(4 * idxQ[0]);
                    end else begin
                        eMcValid = 0; eDone = 1; owner = 0; cooldown = 1;
                    end
                end
            end
            default: begin
                if (bus.mc_ready) begin
                    eLsRes = eMcWr ? 32'd0 : bus.mc_res;
                    eLsReady = 1; eMcValid = 0; owner = 0; cooldown = 1;
                end
            end
        endcase
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " mc_valid"},      32'(bus.mc_valid),      32'(eMcValid));
        checkOutput({tag, " mc_wr"},         32'(bus.mc_wr),         32'(eMcWr));
        checkOutput({tag, " mc_addr"},       bus.mc_addr,            eMcAddr);
        checkOutput({tag, " mc_len"},        32'(bus.mc_len),        32'(eMcLen));
        checkOutput({tag, " mc_data"},       bus.mc_data,            eMcData);
        checkOutput({tag, " if_word_valid"}, 32'(bus.if_word_valid), 32'(eWordValid));
        checkOutput({tag, " if_word_idx"},   32'(bus.if_word_idx),   32'(eWordIdx));
        checkOutput({tag, " if_word"},       bus.if_word,            eWord);
        checkOutput({tag, " if_done"},       32'(bus.if_done),       32'(eDone));
        checkOutput({tag, " ls_ready"},      32'(bus.ls_ready),      32'(eLsReady));
        checkOutput({tag, " ls_res"},        bus.ls_res,             eLsRes);
    endtask

    // Controller stand-in: random latency, one-cycle ready, then one idle cycle.
    task automatic ctrlUpdate();
        if (!ctrlOn || !rdy_in || !rst_n_in) return;
        if (bus.mc_ready) begin
            bus.mc_ready = 0;
            bus.mc_res   = $urandom;
            ctrlCnt      = $urandom_range(ctrlMaxLat, 0);
        end else if (bus.mc_valid) begin
            if (ctrlCnt == 0) begin
                bus.mc_ready = 1;
                bus.mc_res   = memData(bus.mc_addr);
            end else begin
                ctrlCnt--;
            end
        end else begin
            ctrlCnt = $urandom_range(ctrlMaxLat, 0);
        end
    endtask

    task automatic applyStimulus(input string tag);
        @(posedge clk_in);
        #1;
        modelEdge();
        checkModel(tag);
        ctrlUpdate();
    endtask

    task automatic doReset();
        rst_n_in = 0;
        bus.mc_ready = 0;
        #1;
        modelReset();
        checkModel("reset");
        applyStimulus("reset hold");
        rst_n_in = 1;
    endtask

    initial begin
        bus.if_valid = 0; bus.if_addr = 0;
        bus.ls_valid = 0; bus.ls_wr = 0; bus.ls_addr = 0; bus.ls_len = 0; bus.ls_data = 0;
        bus.mc_ready = 0; bus.mc_res = 0;
        modelReset();
        #2;
        doReset();

        vecs[0] = mkVec(1, 0, 32'h100,   3'd2, 32'h0,        0, 32'h0,        1, 0, 32'h100,   0, 32'h0);
        vecs[1] = mkVec(1, 0, 32'h100,   3'd2, 32'h0,        0, 32'h0,        1, 0, 32'h100,   0, 32'h0);
        vecs[2] = mkVec(1, 0, 32'h100,   3'd2, 32'h0,        1, 32'hDEADBEEF, 0, 0, 32'h100,   1, 32'hDEADBEEF);
        vecs[3] = mkVec(1, 0, 32'h100,   3'd2, 32'h0,        0, 32'h0,        0, 0, 32'h100,   0, 32'hDEADBEEF);
        vecs[4] = mkVec(0, 0, 32'h100,   3'd2, 32'h0,        0, 32'h0,        0, 0, 32'h100,   0, 32'hDEADBEEF);
        vecs[5] = mkVec(1, 1, 32'h30000, 3'd2, 32'hCAFEF00D, 0, 32'h0,        1, 1, 32'h30000, 0, 32'hDEADBEEF);
        vecs[6] = mkVec(1, 1, 32'h30000, 3'd2, 32'hCAFEF00D, 0, 32'h0,        1, 1, 32'h30000, 0, 32'hDEADBEEF);
        vecs[7] = mkVec(1, 1, 32'h30000, 3'd2, 32'hCAFEF00D, 1, 32'h11111111, 0, 1, 32'h30000, 1, 32'h0);
        vecs[8] = mkVec(1, 1, 32'h30000, 3'd2, 32'hCAFEF00D, 0, 32'h0,        0, 1, 32'h30000, 0, 32'h0);
        vecs[9] = mkVec(0, 1, 32'h30000, 3'd2, 32'hCAFEF00D, 0, 32'h0,        0, 1, 32'h30000, 0, 32'h0);

        for (int i = 0; i < 10; i++) begin
            bus.ls_valid = vecs[i].lsValid; bus.ls_wr = vecs[i].lsWr; bus.ls_addr = vecs[i].lsAddr;
            bus.ls_len = vecs[i].lsLen; bus.ls_data = vecs[i].lsData;
            bus.mc_ready = vecs[i].mcReady; bus.mc_res = vecs[i].mcRes;
            applyStimulus($sformatf("vec%0d model", i));
            checkOutput($sformatf("vec%0d mc_valid", i), 32'(bus.mc_valid), 32'(vecs[i].expMcValid));
            checkOutput($sformatf("vec%0d mc_wr", i),    32'(bus.mc_wr),    32'(vecs[i].expMcWr));
            checkOutput($sformatf("vec%0d mc_addr", i),  bus.mc_addr,       vecs[i].expMcAddr);
            checkOutput($sformatf("vec%0d ls_ready", i), 32'(bus.ls_ready), 32'(vecs[i].expLsReady));
            checkOutput($sformatf("vec%0d ls_res", i),   bus.ls_res,        vecs[i].expLsRes);
        end
        bus.mc_ready = 0;

        // Full line refill with a zero-latency controller.
        ctrlOn = 1; ctrlMaxLat = 0; ctrlCnt = 0;
        bus.if_valid = 1; bus.if_addr = 32'h40;
        addrs.delete(); words = 0; gotDone = 0; prevValid = 0; prevAddr = 0;
        for (int c = 0; c < 40 && !gotDone; c++) begin
            applyStimulus("refill");
            if (bus.mc_valid && (!prevValid || bus.mc_addr != prevAddr)) addrs.push_back(bus.mc_addr);
            prevValid = bus.mc_valid; prevAddr = bus.mc_addr;
            if (bus.if_word_valid) begin
                checkOutput("refill idx", 32'(bus.if_word_idx), 32'(words));
                checkOutput("refill data", bus.if_word, memData(32'h40 + 32'(4 * words)));
                words++;
            end
            if (bus.if_done) begin
                gotDone = 1;
                checkOutput("refill done on idx3", {29'd0, bus.if_word_valid, bus.if_word_idx}, 32'd7);
            end
        end
        bus.if_valid = 0;
        checkOutput("refill completed", 32'(gotDone), 32'd1);
        checkOutput("refill words", 32'(words), 32'd4);
        checkOutput("refill mc requests", 32'(addrs.size()), 32'd4);
        for (int k = 0; k < addrs.size(); k++)
            checkOutput($sformatf("refill mc_addr %0d", k), addrs[k], 32'h40 + 32'(4 * k));
        repeat (3) applyStimulus("idle");

        // Tie from reset: icache, LSB, icache.
        doReset();
        bus.if_valid = 1; bus.if_addr = 32'h200;
        bus.ls_valid = 1; bus.ls_wr = 0; bus.ls_addr = 32'h300; bus.ls_len = 3'd2;
        grants.delete(); prevValid = 0;
        for (int c = 0; c < 100 && grants.size() < 3; c++) begin
            applyStimulus("tie");
            if (bus.mc_valid && !prevValid) grants.push_back(bus.mc_addr);
            prevValid = bus.mc_valid;
        end
        bus.ls_valid = 0;
        checkOutput("tie grant count", 32'(grants.size()), 32'd3);
        for (int k = 0; k < grants.size(); k++)
            checkOutput($sformatf("tie grant %0d", k), grants[k], (k == 1) ? 32'h300 : 32'h200);
        gotDone = 0;
        for (int c = 0; c < 40 && !gotDone; c++) begin
            applyStimulus("tie drain");
            if (bus.if_done) gotDone = 1;
        end
        bus.if_valid = 0;
        checkOutput("tie drain done", 32'(gotDone), 32'd1);
        repeat (2) applyStimulus("idle");

        // Flush during word 1, with a load waiting behind the refill.
        bus.if_valid = 1; bus.if_addr = 32'h80;
        words = 0; gotDone = 0; cleared = 0; addrs.delete(); prevValid = 0;
        for (int c = 0; c < 40 && !gotDone; c++) begin
            applyStimulus("clear");
            if (bus.mc_valid && (!prevValid || bus.mc_addr != prevAddr)) addrs.push_back(bus.mc_addr);
            prevValid = bus.mc_valid; prevAddr = bus.mc_addr;
            clear_in = 0;
            if (bus.if_word_valid) begin
                checkOutput("clear idx", 32'(bus.if_word_idx), 32'(words));
                words++;
            end
            if (bus.if_word_valid && !cleared) begin
                clear_in = 1; cleared = 1;
                bus.ls_valid = 1; bus.ls_wr = 0; bus.ls_addr = 32'h500; bus.ls_len = 3'd6;
            end
            if (bus.if_done) begin
                gotDone = 1;
                bus.if_valid = 0;
            end
        end
        checkOutput("clear done", 32'(gotDone), 32'd1);
        checkOutput("clear words", 32'(words), 32'd1);
        checkOutput("clear mc requests", 32'(addrs.size()), 32'd2);
        sawGrant = 0; lsDone = 0;
        for (int c = 0; c < 20 && !lsDone; c++) begin
            applyStimulus("clear ls");
            if (bus.mc_valid && !sawGrant) begin
                sawGrant = 1;
                checkOutput("clear next grant", bus.mc_addr, 32'h500);
            end
            if (bus.ls_ready) begin
                lsDone = 1;
                bus.ls_valid = 0;
            end
        end
        checkOutput("clear ls served", 32'(lsDone), 32'd1);
        repeat (2) applyStimulus("idle");

        // Freeze for three cycles after the first refill word.
        ctrlMaxLat = 1;
        bus.if_valid = 1; bus.if_addr = 32'hC0;
        words = 0; gotDone = 0;
        for (int c = 0; c < 60 && !gotDone; c++) begin
            applyStimulus("freeze");
            if (bus.if_word_valid) words++;
            if (bus.if_done) begin
                gotDone = 1;
                bus.if_valid = 0;
            end
            if (words == 1 && bus.if_word_valid && bus.if_word_idx == 0) begin
                prevAddr = bus.mc_addr;
                rdy_in = 0;
                for (int f = 0; f < 3; f++) begin
                    applyStimulus("frozen");
                    checkOutput("frozen pulse held", 32'(bus.if_word_valid), 32'd1);
                    checkOutput("frozen mc_addr", bus.mc_addr, prevAddr);
                end
                rdy_in = 1;
            end
        end
        checkOutput("freeze done", 32'(gotDone), 32'd1);
        checkOutput("freeze words", 32'(words), 32'd4);
        repeat (2) applyStimulus("idle");

        // Reset in the middle of a load the controller never answers.
        ctrlOn = 0;
        bus.ls_valid = 1; bus.ls_wr = 0; bus.ls_addr = 32'h600; bus.ls_len = 3'd1;
        applyStimulus("midload");
        applyStimulus("midload");
        #2;
        bus.ls_valid = 0;
        doReset();
        repeat (3) applyStimulus("post reset");
        bus.ls_valid = 1; bus.ls_addr = 32'h700;
        applyStimulus("post reset grant");
        checkOutput("post reset grant", 32'(bus.mc_valid), 32'd1);
        ctrlOn = 1; ctrlMaxLat = 0; ctrlCnt = 0;
        lsDone = 0;
        for (int c = 0; c < 20 && !lsDone; c++) begin
            applyStimulus("post reset ls");
            if (bus.ls_ready) begin
                lsDone = 1;
                bus.ls_valid = 0;
            end
        end
        checkOutput("post reset ls served", 32'(lsDone), 32'd1);

        // Random traffic with flushes and stalls against the model.
        ctrlMaxLat = 3;
        for (int c = 0; c < 3000; c++) begin
            applyStimulus("random");
            if (bus.if_done) bus.if_valid = 0;
            if (bus.ls_ready) bus.ls_valid = 0;
            if (!bus.if_valid && !bus.if_done && $urandom_range(3, 0) == 0) begin
                bus.if_valid = 1;
                bus.if_addr  = $urandom & 32'hFFFF_FFF0;
            end
            if (!bus.ls_valid && !bus.ls_ready && $urandom_range(3, 0) == 0) begin
                bus.ls_valid = 1;
                bus.ls_wr    = 1'($urandom_range(1, 0));
                bus.ls_addr  = $urandom;
                bus.ls_len   = {1'($urandom_range(1, 0)), 2'($urandom_range(2, 0))};
                bus.ls_data  = $urandom;
            end
            clear_in = ($urandom_range(15, 0) == 0);
            rdy_in   = ($urandom_range(7, 0) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer that shares the single byte-serial memory controller between the instruction cache (line refills) and the load/store buffer (single loads and stores). The block holds the controller's request lines stable until the controller completes. It expands one icache line refill into LINE_WORDS consecutive word reads and routes each result back to its owner. It also discards in-flight instruction fetches on a pipeline clear.

## Interface
- LINE_WORDS, 4, words per icache line; power of two, ≥1; IDX_W = max(1, log2(LINE_WORDS)).
- clk_in  in  1  clock.
- rst_n_in  in  1  reset; asynchronous, active-low.
- rdy_in  in  1  global enable; low freezes all state, and every registered output holds its value.
- clear_in  in  1  pipeline flush; cancels the icache refill.
- if_valid  in  1  icache refill request; level signal, held until if_done.
- if_addr  in  32  line base address; low log2(LINE_WORDS)+2 bits are zero.
- if_word_valid  out  1  one-cycle pulse: if_word holds refill word number if_word_idx.
- if_word_idx  out  IDX_W  word index within the line.
- if_word  out  32  refill data.
- if_done  out  1  one-cycle pulse on the last word, or on the cancellation ack.
- ls_valid  in  1  load/store request; level signal, held until ls_ready.
- ls_wr  in  1  1 = store.
- ls_addr  in  32  byte address.
- ls_len  in  3  controller len code: [1:0] 0/1/2 = byte/half/word; [2] = sign-extend.
- ls_data  in  32  store data.
- ls_ready  out  1  one-cycle completion pulse.
- ls_res  out  32  load result; 0 for stores.
- mc_valid, mc_wr, mc_addr[32], mc_len[3], mc_data[32]  out  controller request; all registered.
- mc_ready  in  1  controller one-cycle done pulse.
- mc_res  in  32  controller result; valid while mc_ready=1.

## Operation
- States:
  - IDLE: no request in flight.
  - BUSY_I: serving an icache refill.
  - BUSY_D: serving a load/store.
  - DONE: one cycle after every completion. No grant is issued in DONE, so a requester that drops its valid only after seeing its pulse is never re-granted.
- Grant rule in IDLE:
  - One requester valid: grant it.
  - Both valid: grant the requester that was not granted last. last_grant resets to "data", so icache wins the first tie.
  - if_valid is ignored while clear_in=1.
- Grant to icache: mc_valid=1, mc_wr=0, mc_len=3'b010, mc_addr=if_addr, word counter=0, cancel flag=0, go to BUSY_I.
- Grant to LSB: copy ls_wr/ls_addr/ls_len/ls_data to mc_*, set mc_valid=1, go to BUSY_D.
- BUSY_I, on mc_ready:
  - If not cancelled: pulse if_word_valid with if_word=mc_res and if_word_idx=counter.
  - If counter<LINE_WORDS-1 and not cancelled: counter+1, mc_addr+4, mc_valid stays 1, stay in BUSY_I.
  - Otherwise: mc_valid=0, pulse if_done, go to DONE.
- clear_in during BUSY_I:
  - Sets the cancel flag.
  - The word already requested from the controller still completes, because the controller cannot be aborted. Its data is dropped and no if_word_valid is issued.
  - if_done still pulses to release the icache.
  - clear_in on the same cycle as mc_ready counts as cancelled for that word.
- BUSY_D, on mc_ready:
  - ls_res = mc_res for loads, 0 for stores.
  - Pulse ls_ready, drop mc_valid, go to DONE.
  - clear_in has no effect on BUSY_D; the LSB owns its own cancellation.
- DONE: go to IDLE the next cycle. Pulse outputs deassert.
- mc_valid only falls on the edge that samples mc_ready=1, so the controller sees a stable request for its whole operation.
- mc_data, mc_wr and mc_len never change while mc_valid=1. mc_addr changes only on the refill step edge.

## Timing
- Reset (async assert): state=IDLE, last_grant=data, counter=0, cancel flag=0. Every output is 0: mc_*, if_*, ls_*.
- Grant latency: request sampled in IDLE at edge E → mc_valid=1 after E.
- Completion: mc_ready sampled at edge F → response pulse visible in the cycle after F.
- Back-to-back refill words: the next mc_addr is presented in the same cycle the controller spends deasserting its ready.
- Grant spacing: a new grant is possible no earlier than two edges after a completion.
- rdy_in=0: no transitions, and pulses are held rather than re-issued. mc_ready is only honoured when rdy_in=1.
- Reset mid-transaction: in-flight state is discarded, no response pulse is issued, and the outputs return to their reset values.

## Test plan
- LSB word load alone: ls_valid=1, ls_addr=0x100, ls_len=2, controller returns 0xDEADBEEF → exactly one ls_ready pulse with ls_res=0xDEADBEEF, then one DONE cycle, then IDLE; mc_* stable throughout.
- Icache refill, LINE_WORDS=4, if_addr=0x40 → mc_addr sequence 0x40, 0x44, 0x48, 0x4C; four if_word_valid pulses with idx 0..3; if_done coincides with idx 3.
- Both requesters valid from reset → icache granted first; with both held, grants alternate: icache, LSB, icache.
- clear_in during word 1 of a refill → word 1 completes on the controller; if_word_valid occurs only for idx 0; if_done pulses; no further mc requests; a pending ls_valid is granted next.
- Store to 0x30000 with ls_wr=1 → mc_wr=1 held until mc_ready; ls_ready pulses with ls_res=0; no re-grant while ls_valid is still high in the DONE cycle.
- rdy_in low for 3 cycles mid-refill and rst_n_in asserted mid-load → state frozen then resumed correctly; after reset, all outputs are 0 and the arbiter is in IDLE.
